// File: rtl/dcmi_pattern_source.sv
// dcmi_pattern_source: burst byte generator feeding a DCMITransmitter.
// On an accepted START it clears the transmitter buffer, writes LEN pattern
// bytes at a fixed pace (GAP_CYCLES idle cycles between writes) and then
// pulses DONE to launch the DCMI transfer. All outputs are registered.
// Optional feature: define DCMI_PATGEN_LFSR_EN to make MODE=1 select an
// 8-bit Galois LFSR pattern (mask 8'hB8); otherwise the incrementing counter
// pattern is always used and MODE is ignored.
module dcmi_pattern_source #(
  parameter int LEN_W      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic [7:0]       SEED,
  input  logic             MODE,
  output logic [7:0]       DO,
  output logic             WR,
  output logic             RST,
  output logic             DONE,
  output logic             BUSY
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WRITE,
    S_GAP,
    S_LAUNCH
  } state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;      // bytes still to be written
  logic [7:0]       pat_q, pat_d;      // next byte to be written
  logic [7:0]       pat_next;
  logic [7:0]       seed_first;
  logic [GAP_W-1:0] gap_q, gap_d;      // idle cycles left in GAP
  logic [7:0]       do_d;
  logic             wr_d, rst_d, done_d, busy_d;
  logic             emit;

`ifdef DCMI_PATGEN_LFSR_EN
  logic             mode_q, mode_d;

  // Advance the pattern: Galois LFSR when MODE was latched high, else counter.
  always_comb begin
    pat_next   = pat_q + 8'd1;
    seed_first = SEED;
    if (mode_q) begin
      pat_next = pat_q[0] ? ((pat_q >> 1) ^ 8'hB8) : (pat_q >> 1);
    end
    // An all-zero LFSR state would lock up, so a zero seed starts at 8'h01.
    if (MODE && (SEED == 8'h00)) begin
      seed_first = 8'h01;
    end
  end
`else
  logic             mode_unused;
  assign mode_unused = MODE;

  // Advance the pattern: incrementing counter, wrapping 8'hFF -> 8'h00.
  always_comb begin
    pat_next   = pat_q + 8'd1;
    seed_first = SEED;
  end
`endif

  // Next-state and next-output decode; outputs are computed one cycle ahead
  // so that the registered outputs line up with the state they belong to.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d = state;
    rem_d   = rem_q;
    pat_d   = pat_q;
    gap_d   = gap_q;
    do_d    = DO;
    wr_d    = 1'b0;
    rst_d   = 1'b0;
    done_d  = 1'b0;
    emit    = 1'b0;
`ifdef DCMI_PATGEN_LFSR_EN
    mode_d  = mode_q;
`endif
    case (state)
      S_IDLE: begin
        // START with a zero length is dropped without any outputs.
        if (START && (LEN != '0)) begin
          rem_d   = LEN;
          pat_d   = seed_first;
`ifdef DCMI_PATGEN_LFSR_EN
          mode_d  = MODE;
`endif
          rst_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: emit = 1'b1;
      S_WRITE: begin
        if (rem_q == '0) begin
          // Last byte just went out: launch immediately, no trailing gap.
          done_d  = 1'b1;
          state_d = S_LAUNCH;
        end else if (GAP_CYCLES > 0) begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          emit = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          emit = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_LAUNCH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (emit) begin
      wr_d    = 1'b1;
      do_d    = pat_q;
      pat_d   = pat_next;
      rem_d   = rem_q - LEN_W'(1);
      state_d = S_WRITE;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; Rst aborts any burst without a DONE.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Rst) begin
      state  <= S_IDLE;
      rem_q  <= '0;
      pat_q  <= 8'h00;
      gap_q  <= '0;
      DO     <= 8'h00;
      WR     <= 1'b0;
      RST    <= 1'b0;
      DONE   <= 1'b0;
      BUSY   <= 1'b0;
`ifdef DCMI_PATGEN_LFSR_EN
      mode_q <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      rem_q  <= rem_d;
      pat_q  <= pat_d;
      gap_q  <= gap_d;
      DO     <= do_d;
      WR     <= wr_d;
      RST    <= rst_d;
      DONE   <= done_d;
      BUSY   <= busy_d;
`ifdef DCMI_PATGEN_LFSR_EN
      mode_q <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_dcmi_pattern_source.sv
// Self-checking bench for dcmi_pattern_source: two instances share stimulus,
// one with back-to-back writes (GAP_CYCLES=0) and one with GAP_CYCLES=2.
// Cycle n is the clock period following rising edge n-1; START is sampled on
// edge 0, so cycle 1 is the first cycle that shows a registered response.
module tb_dcmi_pattern_source;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       seed;
  logic             mode;

  logic [7:0] dout0, dout2;
  logic       wr0, clr0, done0, busy0;
  logic       wr2, clr2, done2, busy2;

  int tests = 0;
  int fails = 0;
  int overlap_cnt = 0;

  logic [7:0] log_do  [1:16];
  logic [3:0] log_ctl [1:16];   // {WR, RST, DONE, BUSY}

  dcmi_pattern_source #(.LEN_W(LEN_W), .GAP_CYCLES(0)) dut0 (
    .Clk(clk), .Rst(rst), .START(start), .LEN(len), .SEED(seed), .MODE(mode),
    .DO(dout0), .WR(wr0), .RST(clr0), .DONE(done0), .BUSY(busy0)
  );

  dcmi_pattern_source #(.LEN_W(LEN_W), .GAP_CYCLES(2)) dut2 (
    .Clk(clk), .Rst(rst), .START(start), .LEN(len), .SEED(seed), .MODE(mode),
    .DO(dout2), .WR(wr2), .RST(clr2), .DONE(done2), .BUSY(busy2)
  );

  always #5 clk = ~clk;

  // WR, RST and DONE must never be high together on either instance.
  always @(negedge clk) begin
    if (((wr0 & clr0) | (wr0 & done0) | (clr0 & done0)) === 1'b1) overlap_cnt++;
    if (((wr2 & clr2) | (wr2 & done2) | (clr2 & done2)) === 1'b1) overlap_cnt++;
  end

  task automatic launch(input logic [LEN_W-1:0] l, input logic [7:0] s, input logic m);
    @(negedge clk);
    len   = l;
    seed  = s;
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Record cycles 1..n of one instance; optionally pulse START at cycle poke.
  task automatic capture(input int sel, input int n, input int poke);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sel == 0) begin
        log_do[c]  = dout0;
        log_ctl[c] = {wr0, clr0, done0, busy0};
      end else begin
        log_do[c]  = dout2;
        log_ctl[c] = {wr2, clr2, done2, busy2};
      end
      if (c == poke) begin
        start = 1'b1;
        len   = 16'd7;
        seed  = 8'h99;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 400 && !(busy0 === 1'b0 && busy2 === 1'b0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy0=%b busy2=%b still set after %0d cycles", busy0, busy2, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; seed = 8'h00; mode = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({dout0, wr0, clr0, done0, busy0} !== 12'h000) begin
      fails++;
      $display("FAIL reset_dut0: got %h expected 000", {dout0, wr0, clr0, done0, busy0});
    end
    tests++;
    if ({dout2, wr2, clr2, done2, busy2} !== 12'h000) begin
      fails++;
      $display("FAIL reset_dut2: got %h expected 000", {dout2, wr2, clr2, done2, busy2});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midburst();
    launch(16'd100, 8'h00, 1'b0);
    for (int c = 1; c <= 12; c++) @(negedge clk);
    // Cycle 12 carries byte 10.
    tests++;
    if ({wr0, dout0} !== {1'b1, 8'h0A}) begin
      fails++;
      $display("FAIL midburst_byte10: wr,do=%b,%h expected 1,0a", wr0, dout0);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({dout0, wr0, clr0, done0, busy0} !== 12'h000) begin
      fails++;
      $display("FAIL midburst_abort0: got %h expected 000", {dout0, wr0, clr0, done0, busy0});
    end
    tests++;
    if ({dout2, wr2, clr2, done2, busy2} !== 12'h000) begin
      fails++;
      $display("FAIL midburst_abort2: got %h expected 000", {dout2, wr2, clr2, done2, busy2});
    end
    // Release reset and request a new burst on the very next edge.
    rst = 1'b0; len = 16'd2; seed = 8'h50; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    capture(0, 5, 0);
    begin
      logic [3:0] ec [1:5];
      ec = '{4'b0101, 4'b1001, 4'b1001, 4'b0011, 4'b0000};
      for (int c = 1; c <= 5; c++) begin
        tests++;
        if (log_ctl[c] !== ec[c]) begin
          fails++;
          $display("FAIL restart_ctl cycle %0d: wr,rst,done,busy=%b expected %b", c, log_ctl[c], ec[c]);
        end
      end
      tests++;
      if ({log_do[2], log_do[3]} !== 16'h5051) begin
        fails++;
        $display("FAIL restart_data: got %h expected 5051", {log_do[2], log_do[3]});
      end
    end
    wait_idle();
  endtask

  task automatic test_counter_gap0();
    logic [3:0] ec [1:8];
    logic [7:0] ed [2:5];
    int         nwr = 0;
    ec = '{4'b0101, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0011, 4'b0000, 4'b0000};
    ed = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    launch(16'd4, 8'hFE, 1'b0);
    capture(0, 8, 0);
    for (int c = 1; c <= 8; c++) begin
      tests++;
      if (log_ctl[c] !== ec[c]) begin
        fails++;
        $display("FAIL gap0_ctl cycle %0d: wr,rst,done,busy=%b expected %b", c, log_ctl[c], ec[c]);
      end
      if (log_ctl[c][3] === 1'b1) nwr++;
    end
    for (int c = 2; c <= 5; c++) begin
      tests++;
      if (log_do[c] !== ed[c]) begin
        fails++;
        $display("FAIL gap0_data cycle %0d: do=%h expected %h", c, log_do[c], ed[c]);
      end
    end
    tests++;
    if (nwr != 4) begin
      fails++;
      $display("FAIL gap0_wr_count: got %0d expected 4", nwr);
    end
    wait_idle();
  endtask

  task automatic test_counter_gap2();
    logic [3:0] ec [1:11];
    logic [7:0] ed [2:8];
    ec = '{4'b0101, 4'b1001, 4'b0001, 4'b0001, 4'b1001, 4'b0001,
           4'b0001, 4'b1001, 4'b0011, 4'b0000, 4'b0000};
    // DO holds the last written byte through each gap.
    ed = '{8'h10, 8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h12};
    launch(16'd3, 8'h10, 1'b0);
    capture(1, 11, 0);
    for (int c = 1; c <= 11; c++) begin
      tests++;
      if (log_ctl[c] !== ec[c]) begin
        fails++;
        $display("FAIL gap2_ctl cycle %0d: wr,rst,done,busy=%b expected %b", c, log_ctl[c], ec[c]);
      end
    end
    for (int c = 2; c <= 8; c++) begin
      tests++;
      if (log_do[c] !== ed[c]) begin
        fails++;
        $display("FAIL gap2_data cycle %0d: do=%h expected %h", c, log_do[c], ed[c]);
      end
    end
    wait_idle();
  endtask

  task automatic test_ignored_start();
    int nwr = 0, ndone = 0;
    // Zero length: no response at all.
    launch(16'd0, 8'h55, 1'b0);
    capture(0, 5, 0);
    for (int c = 1; c <= 5; c++) begin
      tests++;
      if (log_ctl[c] !== 4'b0000) begin
        fails++;
        $display("FAIL len0 cycle %0d: wr,rst,done,busy=%b expected 0000", c, log_ctl[c]);
      end
    end
    // START pulsed (with new LEN/SEED) while busy must not disturb the burst.
    launch(16'd4, 8'h20, 1'b0);
    capture(0, 12, 3);
    for (int c = 1; c <= 12; c++) begin
      if (log_ctl[c][3] === 1'b1) nwr++;
      if (log_ctl[c][1] === 1'b1) ndone++;
    end
    tests++;
    if (nwr != 4 || ndone != 1) begin
      fails++;
      $display("FAIL busy_start_counts: wr=%0d done=%0d expected 4 and 1", nwr, ndone);
    end
    tests++;
    if ({log_do[2], log_do[3], log_do[4], log_do[5]} !== 32'h20212223) begin
      fails++;
      $display("FAIL busy_start_data: got %h expected 20212223",
               {log_do[2], log_do[3], log_do[4], log_do[5]});
    end
    tests++;
    if (log_ctl[6] !== 4'b0011 || log_ctl[7] !== 4'b0000) begin
      fails++;
      $display("FAIL busy_start_done: cycle6=%b cycle7=%b expected 0011 0000", log_ctl[6], log_ctl[7]);
    end
    wait_idle();
  endtask

  task automatic test_lfsr_mode();
    logic [31:0] exp1;
    logic [7:0]  exp0;
`ifdef DCMI_PATGEN_LFSR_EN
    exp1 = 32'h01B85C2E;
    exp0 = 8'h01;
`else
    exp1 = 32'h01020304;
    exp0 = 8'h00;
`endif
    launch(16'd4, 8'h01, 1'b1);
    capture(0, 6, 0);
    tests++;
    if ({log_do[2], log_do[3], log_do[4], log_do[5]} !== exp1) begin
      fails++;
      $display("FAIL mode1_seed01: got %h expected %h",
               {log_do[2], log_do[3], log_do[4], log_do[5]}, exp1);
    end
    wait_idle();
    launch(16'd4, 8'h00, 1'b1);
    capture(0, 3, 0);
    tests++;
    if (log_do[2] !== exp0) begin
      fails++;
      $display("FAIL mode1_seed00_first: got %h expected %h", log_do[2], exp0);
    end
    wait_idle();
  endtask

  task automatic test_exclusive();
    tests++;
    if (overlap_cnt != 0) begin
      fails++;
      $display("FAIL strobe_overlap: %0d cycles with WR/RST/DONE overlap, expected 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midburst();
    test_counter_gap0();
    test_counter_gap2();
    test_ignored_start();
    test_lfsr_mode();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
